// File: rtl/uart_rx_top.sv
// 16x-oversampling UART receiver (8N1) with programmable baud prescaler.
// Define UART_RX_FRAME_ERR_EN to add a frame_err pulse output for bad stop bits.
module uart_rx_top #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_done,
  output logic             baud_tick_16x,
  output logic             baud_tick_1x
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic             frame_err
`endif
);

  localparam logic [3:0] OS_MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OVS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DIV_W-1:0] presc_cnt;
  logic [DIV_W-1:0] div_lim;
  logic [3:0]       tick_cnt;
  logic             rx_meta;
  logic             rx_sync;
  state_t           state;
  logic [3:0]       os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  // A divisor of 0 behaves like 1; >= lets a shrinking divisor wrap at once.
  assign div_lim = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt     <= '0;
      tick_cnt      <= '0;
      baud_tick_16x <= 1'b0;
      baud_tick_1x  <= 1'b0;
    end else if (presc_cnt >= div_lim) begin
      presc_cnt     <= '0;
      baud_tick_16x <= 1'b1;
      baud_tick_1x  <= (tick_cnt == 4'hF);
      tick_cnt      <= tick_cnt + 4'd1;
    end else begin
      presc_cnt     <= presc_cnt + DIV_W'(1);
      baud_tick_16x <= 1'b0;
      baud_tick_1x  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (baud_tick_16x) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          START: begin
            if (os_cnt == OS_MID) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_sync ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shreg   <= {rx_sync, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          STOP: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              state  <= IDLE;
              if (rx_sync) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
              end
`ifdef UART_RX_FRAME_ERR_EN
              else frame_err <= 1'b1;
`endif
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: frames push expected bytes, a monitor pops on rx_done.
module tb_uart_rx_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd5;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        baud_tick_16x;
  logic        baud_tick_1x;
`ifdef UART_RX_FRAME_ERR_EN
  logic        frame_err;
  int          exp_ferr = 0;
  int          ferr_seen = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [7:0]  exp_q[$];

  uart_rx_top dut (
    .clk(clk),
    .rst(rst),
    .baud_div(baud_div),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .baud_tick_16x(baud_tick_16x),
    .baud_tick_1x(baud_tick_1x)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_done cycle must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_done: got %0h expected none", rx_data);
      end else begin
        check("rx_data_on_done", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) ferr_seen++;
`endif
  end

  task automatic hold_rx(input logic v, input int n);
    @(posedge clk);
    #1 rx = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
    if (stop) exp_q.push_back(d);
`ifdef UART_RX_FRAME_ERR_EN
    else exp_ferr++;
`endif
    hold_rx(1'b0, cpb);
    for (int i = 0; i < 8; i++) hold_rx(d[i], cpb);
    if (stop) hold_rx(1'b1, cpb);
    else begin
      hold_rx(1'b0, cpb * 11 / 16);
      hold_rx(1'b1, cpb - cpb * 11 / 16);
    end
  endtask

  task automatic cycles_to_tick16(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!baud_tick_16x && n < 5000);
  endtask

  task automatic cycles_to_tick1x(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!baud_tick_1x && n < 5000);
  endtask

  initial begin
    int n;
    int ok;
    logic [7:0] partial;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_tick16", {31'd0, baud_tick_16x}, 32'd0);
    check("reset_tick1x", {31'd0, baud_tick_1x}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Prescaler spacing at divisor 5
    cycles_to_tick16(n);
    for (int i = 0; i < 3; i++) begin
      cycles_to_tick16(n);
      check("tick16_period_div5", n, 5);
    end
    cycles_to_tick1x(n);
    cycles_to_tick1x(n);
    check("tick1x_period_div5", n, 80);

    // Shrinking the divisor below the running count wraps on the next clock
    baud_div = 16'd100;
    cycles_to_tick16(n);
    cycles_to_tick16(n);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1 baud_div = 16'd5;
    cycles_to_tick16(n);
    check("div_shrink_wrap", n, 2);

    hold_rx(1'b1, 100);
    send_frame(8'hAB, 1'b1, 80);
    hold_rx(1'b1, 40);
    check("after_AB", {24'd0, rx_data}, 32'hAB);

    // False start: low for three ticks only
    hold_rx(1'b0, 15);
    hold_rx(1'b1, 300);
    check("false_start_hold", {24'd0, rx_data}, 32'hAB);
    send_frame(8'h5A, 1'b1, 80);
    hold_rx(1'b1, 40);

    // Framing error
    send_frame(8'h55, 1'b0, 80);
    hold_rx(1'b1, 300);
    check("frame_err_hold", {24'd0, rx_data}, 32'h5A);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 80);
    send_frame(8'hFF, 1'b1, 80);
    hold_rx(1'b1, 40);
    check("after_back_to_back", {24'd0, rx_data}, 32'hFF);

    // Reset during bit 4
    partial = 8'hC3;
    hold_rx(1'b0, 80);
    for (int i = 0; i < 4; i++) hold_rx(partial[i], 80);
    hold_rx(partial[4], 40);
    @(posedge clk);
    #3;
    rst = 1'b1;
    rx = 1'b1;
    #1;
    check("midframe_rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midframe_rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("midframe_rst_tick16", {31'd0, baud_tick_16x}, 32'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    hold_rx(1'b1, 200);
    check("post_rst_idle", {24'd0, rx_data}, 32'h00);
    send_frame(8'h3C, 1'b1, 80);
    hold_rx(1'b1, 40);

    // Divisor 1: tick every clock
    baud_div = 16'd1;
    cycles_to_tick16(n);
    cycles_to_tick16(n);
    ok = 1;
    for (int i = 0; i < 16; i++) begin
      cycles_to_tick16(n);
      if (n != 1) ok = 0;
    end
    check("tick16_every_clk_div1", ok, 1);
    cycles_to_tick1x(n);
    cycles_to_tick1x(n);
    check("tick1x_period_div1", n, 16);
    hold_rx(1'b1, 40);
    send_frame(8'hA5, 1'b1, 16);
    hold_rx(1'b1, 40);

    check("scoreboard_drained", exp_q.size(), 0);
    check("rx_done_count", done_seen, 6);
`ifdef UART_RX_FRAME_ERR_EN
    check("frame_err_count", ferr_seen, exp_ferr);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
